// File: rtl/im_fetch.sv
// im_fetch: 512x32 instruction memory with a program-load port and a registered fetch response.
// Define IM_MISALIGN_CHK_EN to flag fetches whose byte address is not word aligned.
module im_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [10:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [10:0] rsp_addr,
  input  logic        rsp_ready,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ovf,
  output logic        rsp_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [8:0]  wptr_q;
  logic        ld_ovf_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_instr_q;
  logic [10:0] rsp_addr_q;
  logic        rsp_err_q;

  // Contents deliberately survive reset so an aborted load keeps what it wrote.
  logic [31:0] mem [512];

  logic in_load, in_serve, ld_enter, ld_write, flush, accept, misalign;

  assign in_load  = (state_q == LOAD);
  assign in_serve = (state_q == SERVE);
  assign ld_enter = ld_start & ((state_q == IDLE) | in_serve);
  assign ld_write = in_load & ld_valid;
  assign flush    = in_serve & ld_start;

  assign req_ready = in_serve & (~rsp_valid_q | rsp_ready) & ~ld_start;
  assign accept    = req_valid & req_ready;

`ifdef IM_MISALIGN_CHK_EN
  assign misalign = |req_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_start) state_d = LOAD;
      LOAD:    if (ld_valid & ld_last) state_d = SERVE;
      SERVE:   if (ld_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      ld_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_enter) begin
        wptr_q   <= '0;
        ld_ovf_q <= 1'b0;
      end else if (ld_write) begin
        wptr_q <= wptr_q + 9'd1;
        if (wptr_q == 9'd511) ld_ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_write) mem[wptr_q] <= ld_data;
  end

  // A flush wins over everything; otherwise a new accept refills the slot as the old word drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (flush) begin
      rsp_valid_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_instr_q <= misalign ? 32'h0 : mem[req_addr[10:2]];
      rsp_addr_q  <= req_addr;
      rsp_err_q   <= misalign;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign ld_ovf    = ld_ovf_q;

endmodule

// File: tb/tb_im_fetch.sv
// Scoreboard bench for im_fetch: directed scenarios followed by randomized load/fetch traffic.
module tb_im_fetch;

`ifdef IM_MISALIGN_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [10:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [10:0] rsp_addr;
  logic        rsp_ready = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ovf;
  logic        rsp_err;

  always #5 clk = ~clk;

  im_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_ready (rsp_ready),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ovf    (ld_ovf),
    .rsp_err   (rsp_err)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [10:0] addr;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mmem [512];
  int          mode = 0;   // 0 idle, 1 loading, 2 serving
  bit          m_rsp_valid = 1'b0;
  bit          m_ovf = 1'b0;
  int          cnt = 0;    // words written since the current load began
  logic [31:0] last_instr = '0;
  logic [10:0] last_addr = '0;
  bit          started = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented word must match the head of the scoreboard.
  initial begin
    rsp_t tmp;
    forever begin
      @(negedge clk);
      if (started && reset) begin
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got word %h at %h with nothing pending", rsp_instr,
                     rsp_addr);
          end else begin
            chk("rsp_instr", rsp_instr, sb[0].instr);
            chk("rsp_addr", 32'(rsp_addr), 32'(sb[0].addr));
            chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
            if (rsp_ready) begin
              tmp = sb.pop_front();
              last_instr = tmp.instr;
              last_addr  = tmp.addr;
            end
          end
        end else begin
          chk("idle_instr_hold", rsp_instr, last_instr);
          chk("idle_addr_hold", 32'(rsp_addr), 32'(last_addr));
        end
      end
    end
  end

  // One clock of stimulus: check handshake outputs, then advance the reference model.
  task automatic step();
    bit   exp_ready, accept, flush;
    rsp_t e, tmp;
    @(negedge clk);
    exp_ready = (mode == 2) && (!m_rsp_valid || rsp_ready) && !ld_start;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    chk("ld_ovf", 32'(ld_ovf), 32'(m_ovf));
    @(posedge clk);
    accept = req_valid && exp_ready;
    flush  = (mode == 2) && ld_start;
    if (flush) begin
      if (m_rsp_valid && !rsp_ready) begin
        tmp = sb.pop_back();
        last_instr = tmp.instr;
        last_addr  = tmp.addr;
      end
      m_rsp_valid = 1'b0;
    end else if (accept) begin
      e.err   = ChkEn && (req_addr[1:0] != 2'b00);
      e.instr = e.err ? 32'h0 : mmem[req_addr[10:2]];
      e.addr  = req_addr;
      sb.push_back(e);
      m_rsp_valid = 1'b1;
    end else if (m_rsp_valid && rsp_ready) begin
      m_rsp_valid = 1'b0;
    end
    case (mode)
      0, 2: if (ld_start) begin
        mode  = 1;
        cnt   = 0;
        m_ovf = 1'b0;
      end
      1: if (ld_valid) begin
        mmem[cnt % 512] = ld_data;
        cnt++;
        if (cnt % 512 == 0) m_ovf = 1'b1;
        if (ld_last) mode = 2;
      end
      default: ;
    endcase
    #1;
  endtask

  task automatic load_k(input int n, input logic [31:0] base, input logic [31:0] stride);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      ld_valid = 1'b1;
      ld_data  = base + stride * k;
      ld_last  = (k == n - 1);
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [10:0] a, input logic rdy);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = rdy;
    step();
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_instr"}, rsp_instr, 32'd0);
    chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_ld_ovf"}, 32'(ld_ovf), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int w, lo, target, nload;
    #2;
    chk_reset_outputs("por");
    started = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic load and aligned fetch
    load_k(4, 32'h11111111, 32'h11111111);
    fetch(11'h008, 1'b1);
    chk("fetch8_valid", 32'(rsp_valid), 32'd1);
    chk("fetch8_instr", rsp_instr, 32'h33333333);
    chk("fetch8_addr", 32'(rsp_addr), 32'h008);

    // Misaligned fetch
    fetch(11'h005, 1'b1);
    chk("mis_err", 32'(rsp_err), 32'(ChkEn));
    chk("mis_instr", rsp_instr, ChkEn ? 32'h0 : 32'h22222222);
    step();

    // Backpressure with a request waiting
    fetch(11'h000, 1'b0);
    req_valid = 1'b1;
    req_addr  = 11'h00c;
    for (int i = 0; i < 3; i++) step();
    chk("bp_hold_addr", 32'(rsp_addr), 32'h000);
    chk("bp_hold_instr", rsp_instr, 32'h11111111);
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("bp_next_instr", rsp_instr, 32'h44444444);
    chk("bp_next_addr", 32'(rsp_addr), 32'h00c);
    step();

    // Pointer wrap
    load_k(513, 32'd0, 32'd1);
    chk("wrap_ovf", 32'(ld_ovf), 32'd1);
    fetch(11'h000, 1'b1);
    chk("wrap_mem0", rsp_instr, 32'd512);
    fetch(11'h004, 1'b1);
    chk("wrap_mem1", rsp_instr, 32'd1);
    step();

    // Flush while a response is stalled
    fetch(11'h008, 1'b0);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("flush_valid", 32'(rsp_valid), 32'd0);
    chk("flush_ovf", 32'(ld_ovf), 32'd0);
    chk("flush_ready", 32'(req_ready), 32'd0);
    ld_valid = 1'b1;
    ld_data  = 32'ha5a5a5a5;
    ld_last  = 1'b1;
    step();
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    rsp_ready = 1'b1;
    step();

    // Asynchronous reset in the middle of a load
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hb0b0b0b0;
    step();
    ld_data = 32'hb1b1b1b1;
    step();
    ld_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async");
    mode = 0;
    m_rsp_valid = 1'b0;
    m_ovf = 1'b0;
    cnt = 0;
    sb.delete();
    last_instr = '0;
    last_addr  = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 11'h004;
    for (int i = 0; i < 3; i++) step();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    step();
    ld_valid = 1'b1;
    ld_data  = 32'hc0c0c0c0;
    ld_last  = 1'b1;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch(11'h004, 1'b1);
    chk("kept_word", rsp_instr, 32'hb1b1b1b1);
    fetch(11'h000, 1'b1);
    chk("reload_word", rsp_instr, 32'hc0c0c0c0);

    // Randomized traffic
    target = 20;
    for (int i = 0; i < 3000; i++) begin
      rsp_ready = ($urandom % 4) != 0;
      req_valid = $urandom % 2;
      nload = (cnt < 512) ? cnt : 512;
      w  = (nload > 0) ? int'($urandom_range(nload - 1, 0)) : 0;
      lo = (($urandom % 4) == 0) ? int'($urandom % 4) : 0;
      req_addr = {w[8:0], lo[1:0]};
      ld_data  = $urandom;
      if (mode == 1) begin
        ld_valid = ($urandom % 4) != 0;
        ld_last  = ld_valid && (cnt + 1 >= target);
        ld_start = ($urandom % 8) == 0;
      end else begin
        ld_valid = ($urandom % 8) == 0;
        ld_last  = $urandom % 2;
        ld_start = ($urandom % 64) == 0;
        if (ld_start) target = $urandom_range(40, 2);
      end
      step();
    end

    req_valid = 1'b0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
